// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: PC width, FSM states, FIFO entry.
package fetch_pkg;

    localparam int unsigned PC_W = 16;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrain
    } fetch_state_e;

    typedef struct packed {
        pc_t data;
        pc_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Instruction-memory request/response and decode-side handshake of the fetch sequencer.
interface fetch_pc_sequencer_if;
    import fetch_pkg::*;

    logic imem_req;
    pc_t  imem_addr;
    logic imem_gnt;
    logic imem_rvalid;
    pc_t  imem_rdata;
    logic instr_valid;
    pc_t  instr_data;
    pc_t  instr_pc;
    logic instr_ready;

    // Sequencer side.
    modport master (
        output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );

    // Memory and decode side.
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );

endinterface

// File: rtl/fetch_addr_adder.sv
// Kogge-Stone parallel-prefix adder shared by PC increment and redirect target computation.
module fetch_addr_adder import fetch_pkg::*; #(
    parameter int unsigned WIDTH = PC_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] half_sum;
    logic [WIDTH-1:0] grp_gen;
    logic [WIDTH-1:0] grp_prop;
    logic [WIDTH-1:0] lvl_gen;
    logic [WIDTH-1:0] lvl_prop;
    logic [WIDTH-1:0] nxt_gen;
    logic [WIDTH-1:0] nxt_prop;
    logic [WIDTH:0]   carries;

    // Prefix tree: after level l each bit holds group generate/propagate over 2^(l+1) bits.
    always_comb begin
        lvl_gen  = a & b;
        lvl_prop = a ^ b;
        nxt_gen  = lvl_gen;
        nxt_prop = lvl_prop;
        for (int l = 0; l < int'(LEVELS); l++) begin
            nxt_gen  = lvl_gen;
            nxt_prop = lvl_prop;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (i >= (1 << l)) begin
                    nxt_gen[i]  = lvl_gen[i] | (lvl_prop[i] & lvl_gen[i - (1 << l)]);
                    nxt_prop[i] = lvl_prop[i] & lvl_prop[i - (1 << l)];
                end
            end
            lvl_gen  = nxt_gen;
            lvl_prop = nxt_prop;
        end
        grp_gen  = lvl_gen;
        grp_prop = lvl_prop;
    end

    assign half_sum            = a ^ b;
    assign carries[0]          = cin;
    assign carries[WIDTH:1]    = grp_gen | (grp_prop & {WIDTH{cin}});
    assign sum                 = half_sum ^ carries[WIDTH-1:0];
    assign carry               = carries[WIDTH];

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one-outstanding fetches, buffers words for decode.
module fetch_pc_sequencer import fetch_pkg::*; #(
    parameter pc_t         RESET_VEC  = 16'h0000,
    parameter pc_t         INC_STEP   = 16'd1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  redirect_valid,
    input  pc_t                   redirect_base,
    input  pc_t                   redirect_offset,
    fetch_pc_sequencer_if.master  bus,
    output logic                  pc_wrap,
    output logic                  busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_e     state_q;
    pc_t              pc_q;
    pc_t              req_pc_q;
    logic             wrap_q;

    fetch_entry_t     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    pc_t              add_a;
    pc_t              add_b;
    pc_t              add_sum;
    logic             add_carry;

    logic             req;
    logic             gnt_fire;
    logic             push;
    logic             pop;
    logic             flush;

    // Redirect owns the adder whenever present; otherwise it produces PC + INC_STEP.
    always_comb begin
        add_a = pc_q;
        add_b = INC_STEP;
        if (redirect_valid) begin
            add_a = redirect_base;
            add_b = redirect_offset;
        end
    end

    fetch_addr_adder #(
        .WIDTH (PC_W)
    ) u_adder (
        .a     (add_a),
        .b     (add_b),
        .cin   (1'b0),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Request only when a FIFO slot is free for the response; redirect flushes the buffer.
    always_comb begin
        req      = (state_q == StReq) && (count_q < DEPTH_CNT);
        gnt_fire = req && bus.imem_gnt;
        flush    = redirect_valid;
        push     = (state_q == StWait) && bus.imem_rvalid && !redirect_valid;
        pop      = (count_q != '0) && bus.instr_ready;
    end

    // Fetch FSM with PC, in-flight request PC and sticky wrap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_VEC;
            req_pc_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (redirect_valid) begin
                        pc_q    <= add_sum;
                        wrap_q  <= 1'b0;
                        state_q <= StReq;
                    end else if (start) begin
                        pc_q    <= RESET_VEC;
                        wrap_q  <= 1'b0;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (redirect_valid) begin
                        // A request granted this very cycle still owes a response: drain it.
                        pc_q    <= add_sum;
                        wrap_q  <= 1'b0;
                        state_q <= gnt_fire ? StDrain : StReq;
                    end else if (gnt_fire) begin
                        pc_q     <= add_sum;
                        req_pc_q <= pc_q;
                        wrap_q   <= wrap_q | add_carry;
                        state_q  <= StWait;
                    end
                end
                StWait, StDrain: begin
                    if (redirect_valid) begin
                        pc_q    <= add_sum;
                        wrap_q  <= 1'b0;
                        state_q <= bus.imem_rvalid ? StReq : StDrain;
                    end else if (bus.imem_rvalid) begin
                        state_q <= StReq;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Instruction buffer: circular pointers plus occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= '{data: bus.imem_rdata, pc: req_pc_q};
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr_data  = fifo_mem[rd_ptr_q].data;
    assign bus.instr_pc    = fifo_mem[rd_ptr_q].pc;
    assign pc_wrap         = wrap_q;
    assign busy            = (state_q != StIdle);

endmodule
